uart_tx_fifo_baud: RTL
======================

Name: uart_tx_fifo_baud

Overview:
Buffered UART transmitter with run-time baud select. Upstream logic pushes bytes into an internal FIFO. The block serialises them on tx as 8N1 frames, LSB first, back-to-back while data remains. It is the transmit-side counterpart to the team's UART receive/loopback path and uses the same 12 MHz divisor table.

Parameters:
FIFO_DEPTH, 8, byte entries in the FIFO; must be a power of 2, minimum 2.
DIV_110, 109091, clk cycles per bit at baud select 2'b00.
DIV_600, 20000, clk cycles per bit at baud select 2'b01.
DIV_2400, 5000, clk cycles per bit at baud select 2'b10.
DIV_9600, 1250, clk cycles per bit at baud select 2'b11.

Ports:
clk  input  1  system clock (12 MHz nominal).
rst  input  1  reset, asynchronous, active-high.
baud  input  2  baud select; decode per the DIV_* parameters.
wr_en  input  1  push request.
wr_data  input  8  byte to push.
full  output  1  FIFO holds FIFO_DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky; a push was attempted while full.
busy  output  1  a frame is in progress (state != IDLE).
frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.
tx  output  1  serial line, registered, idle high.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: tx=1, busy=0, frame_done=0, overflow=0, empty=1, full=0, level=0. FIFO pointers are cleared and the FSM goes to IDLE.
- Reset mid-frame: tx returns to 1 immediately. Buffered data is discarded.
- FIFO push: when wr_en=1 and full=0 at a clk edge, wr_data is written and level increments.
  - wr_en=1 while full=1: write is dropped and overflow sets. This holds even if a pop occurs in the same cycle, because full is evaluated from the registered level.
  - Push and pop in the same cycle: level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- Bit timing: bit_cnt counts 0..7 in DATA. div_cnt counts 0..div-1, and each state/bit lasts exactly div cycles. div is latched from baud at the pop cycle. A baud change mid-frame has no effect until the next pop.
- IDLE: tx=1.
  - If empty=0, pop the head into the shift register and latch div; next state is START.
  - A byte written to an empty FIFO is popped on the cycle after the write. tx falls on the following cycle, i.e. 2 cycles after the write edge.
- START: tx=0 for div cycles, then go to DATA.
- DATA: tx = shift_reg[0], LSB first. Shift right after each div cycles. After bit 7, go to STOP.
- STOP: tx=1 for div cycles. frame_done pulses on its final cycle.
  - If empty=0 on that final cycle, pop and go directly to START. There is no extra idle gap, so the frame period is exactly 10*div cycles.
  - Otherwise go to IDLE.
- busy=1 in START, DATA and STOP. In IDLE it is 0, except that busy stays 1 on the pop cycle out of IDLE.
- overflow clears only on reset.

Test Plan:
- Basic frame: rst then release; baud=2'b11, DIV_9600=16 for the bench; write 0x55 once. Required: tx=0 for 16 cycles starting 2 cycles after the write, then 1,0,1,0,1,0,1,0 (16 cycles each), then stop high for 16 cycles; frame_done pulses once; busy falls afterwards; empty=1.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles. Required: three frames with no idle gap, exactly 160 cycles each; level goes 1,2,... then decrements at each pop; three frame_done pulses.
- Overflow/full: with tx stalled mid-frame, write FIFO_DEPTH+1 bytes (0x00..0x08). Required: full=1 at level 8; 0x08 is dropped and overflow=1; subsequent output is 0x00..0x07 in order; overflow stays 1.
- Baud latch: start frame 0x0F at baud=2'b11, then switch baud to 2'b10 mid-frame. Required: current frame keeps DIV_9600 timing; the next queued byte uses DIV_2400.
- Reset mid-frame: assert rst during DATA bit 3 of 0x00. Required: tx=1 asynchronously; level=0 and empty=1; no frame_done; the block is ready to accept a new write after release.
- Pointer wrap: push/pop 20 bytes (0x10..0x23) at a rate that keeps level between 1 and 3. Required: all bytes are transmitted in order, unchanged, across the pointer wrap.

Source files
------------

// File: rtl/uart_tx_fifo_baud.sv
// uart_tx_fifo_baud: buffered 8N1 UART transmitter.
// Bytes pushed into a small FIFO are sent LSB first, back to back, at a
// bit period chosen by 'baud'. The divisor is captured when a byte is popped.
module uart_tx_fifo_baud #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_110    = 109091,
  parameter int unsigned DIV_600    = 20000,
  parameter int unsigned DIV_2400   = 5000,
  parameter int unsigned DIV_9600   = 1250
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    baud,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          tx
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  // Transmit engine
  state_t        state_q, state_d;
  logic [31:0]   div_q, div_d, div_sel;
  logic [31:0]   div_cnt_q, div_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          frame_done_q, frame_done_d;
  logic          bit_last;

  // Status is derived from the registered level so a same-cycle pop never
  // opens room for a push.
  assign full     = (level_q == DEPTH_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign push     = wr_en && !full;
  assign bit_last = (div_cnt_q == div_q - 32'd1);

  // A non-IDLE state, or the pop cycle leaving IDLE, counts as busy.
  assign busy       = (state_q != IDLE) || !empty;
  assign frame_done = frame_done_q;
  assign tx         = tx_q;

  // Decode the run-time baud select into a bit period in clk cycles.
  always_comb begin
    unique case (baud)
      2'b00:   div_sel = DIV_110;
      2'b01:   div_sel = DIV_600;
      2'b10:   div_sel = DIV_2400;
      default: div_sel = DIV_9600;
    endcase
  end

  // FIFO pointer, level and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (wr_en && full);
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Frame FSM: sequencing, bit timing, pop requests and registered tx.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q + 32'd1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pop          = 1'b0;
    tx_d         = 1'b1;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          div_d   = div_sel;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_last) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_last) begin
          div_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_last) begin
          frame_done_d = 1'b1;
          div_cnt_d    = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            div_d   = div_sel;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset returns the line high and discards buffered data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      div_q        <= DIV_9600;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO data write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only read after it was written.
    if (push) fifo_mem[wr_ptr_q] <= wr_data;
  end

endmodule
